// File: rtl/bf_mem_responder.sv
// -----------------------------------------------------------------------------
// bf_mem_responder
// Serves the BF core's memory requests (instruction fetch, cell read, cell
// write) over a nibble-serial external bus to off-chip program/tape memory.
//
// A transaction is framed by ext_cs_n_o low. The block sends a command nibble
// (4'h2 write / 4'h1 read), then the address MSB nibble first. A write then
// sends the data high nibble first. A read turns the bus around for one cycle
// and then collects two nibbles, high nibble first. Every nibble moves only on
// a cycle with ext_rdy_i=1. A run of TIMEOUT stalled cycles aborts the
// transaction with err_o=1.
//
// Ports
//   clk          clock
//   nreset       synchronous active-low reset
//   en_i         design enable; 0 freezes every register and output
//   req_i        core request, sampled only while idle
//   we_i         1 = write, 0 = read (latched with req_i)
//   addr_i       byte address (latched with req_i)
//   wdata_i      write data (latched with req_i)
//   ack_o        one en-qualified cycle completion pulse
//   err_o        valid with ack_o; 1 = aborted by stall timeout
//   rdata_o      read data, valid from ack_o until the next ack_o
//   busy_o       high in every state except idle
//   ext_cs_n_o   frame select, low for the whole transfer
//   ext_oe_o     1 = block drives ext_dout_o onto the shared pins
//   ext_dout_o   outgoing nibble (zero whenever ext_oe_o=0)
//   ext_din_i    incoming nibble
//   ext_rdy_i    external side accepts/presents a nibble this cycle
//
// All outputs come straight from flops. Their next values are decoded from
// the next-state values, so each output matches the state it belongs to.
// -----------------------------------------------------------------------------
module bf_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              en_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    output logic              ack_o,
    output logic              err_o,
    output logic [7:0]        rdata_o,
    output logic              busy_o,
    output logic              ext_cs_n_o,
    output logic              ext_oe_o,
    output logic [3:0]        ext_dout_o,
    input  logic [3:0]        ext_din_i,
    input  logic              ext_rdy_i
);

    localparam int NIB     = ADDR_W / 4;
    localparam int IDX_W   = (NIB > 2) ? $clog2(NIB) : 1;
    localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NIB - 1);
    // The abort happens in the cycle whose stall would bring the count to TIMEOUT.
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WDATA = 3'd3,
        ST_TURN  = 3'd4,
        ST_RDATA = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Address nibble number i, counted from the most significant nibble.
    function automatic logic [3:0] addr_nib(input logic [ADDR_W-1:0] a,
                                            input logic [IDX_W-1:0]  i);
        logic [3:0] r;
        r = 4'h0;
        for (int k = 0; k < NIB; k++) begin
            if (i == IDX_W'(NIB - 1 - k)) begin
                r = a[k*4 +: 4];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Registers and their next-state values
    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [3:0]          rhi_q, rhi_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                cs_n_q, cs_n_d;
    logic                oe_q, oe_d;
    logic [3:0]          dout_q, dout_d;

    logic                abort_s;
    logic                timeout_hit_s;
    logic [STALL_W-1:0]  stall_inc_s;

    assign timeout_hit_s = (TIMEOUT != 0) && (stall_q == STALL_LAST);
    // With TIMEOUT=0 the counter is parked so it never wraps into a false abort.
    assign stall_inc_s   = (TIMEOUT != 0) ? (stall_q + STALL_W'(1)) : stall_q;

    // Next-state, nibble index, stall counter and latched-request logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stall_d = stall_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rhi_d   = rhi_q;
        rdata_d = rdata_q;
        abort_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d = ST_CMD;
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    idx_d   = '0;
                    stall_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CMD: begin
                if (ext_rdy_i) begin
                    state_d = ST_ADDR;
                    idx_d   = '0;
                    stall_d = '0;
                end else if (timeout_hit_s) begin
                    state_d = ST_DONE;
                    abort_s = 1'b1;
                end else begin
                    stall_d = stall_inc_s;
                end
            end

            ST_ADDR: begin
                if (ext_rdy_i) begin
                    stall_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = we_q ? ST_WDATA : ST_TURN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (timeout_hit_s) begin
                    state_d = ST_DONE;
                    abort_s = 1'b1;
                end else begin
                    stall_d = stall_inc_s;
                end
            end

            ST_WDATA: begin
                if (ext_rdy_i) begin
                    stall_d = '0;
                    if (idx_q != '0) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = IDX_W'(1);
                    end
                end else if (timeout_hit_s) begin
                    state_d = ST_DONE;
                    abort_s = 1'b1;
                end else begin
                    stall_d = stall_inc_s;
                end
            end

            ST_TURN: begin
                // Bus turnaround: exactly one cycle, ext_rdy_i has no effect.
                state_d = ST_RDATA;
                idx_d   = '0;
                stall_d = '0;
            end

            ST_RDATA: begin
                if (ext_rdy_i) begin
                    stall_d = '0;
                    if (idx_q != '0) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                        rdata_d = {rhi_q, ext_din_i};
                    end else begin
                        rhi_d = ext_din_i;
                        idx_d = IDX_W'(1);
                    end
                end else if (timeout_hit_s) begin
                    state_d = ST_DONE;
                    abort_s = 1'b1;
                end else begin
                    stall_d = stall_inc_s;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                stall_d = '0;
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                stall_d = '0;
            end
        endcase

        // An aborted transfer reports zero data for reads and writes alike.
        if (abort_s) begin
            rdata_d = 8'h00;
            stall_d = '0;
            idx_d   = '0;
        end else begin
            rdata_d = rdata_d;
        end
    end

    // Output decode from the next-state values, captured by the output flops
    always_comb begin
        ack_d  = 1'b0;
        err_d  = 1'b0;
        busy_d = 1'b1;
        cs_n_d = 1'b0;
        oe_d   = 1'b0;
        dout_d = 4'h0;

        case (state_d)
            ST_IDLE: begin
                busy_d = 1'b0;
                cs_n_d = 1'b1;
            end
            ST_CMD: begin
                oe_d   = 1'b1;
                dout_d = we_d ? 4'h2 : 4'h1;
            end
            ST_ADDR: begin
                oe_d   = 1'b1;
                dout_d = addr_nib(addr_d, idx_d);
            end
            ST_WDATA: begin
                oe_d   = 1'b1;
                dout_d = (idx_d == '0) ? wdata_d[7:4] : wdata_d[3:0];
            end
            ST_TURN: begin
                oe_d = 1'b0;
            end
            ST_RDATA: begin
                oe_d = 1'b0;
            end
            ST_DONE: begin
                cs_n_d = 1'b1;
                ack_d  = 1'b1;
                err_d  = abort_s;
            end
            default: begin
                busy_d = 1'b0;
                cs_n_d = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers; en_i=0 holds everything
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            stall_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            rhi_q   <= 4'h0;
            rdata_q <= 8'h00;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            dout_q  <= 4'h0;
        end else if (en_i) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stall_q <= stall_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rhi_q   <= rhi_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            cs_n_q  <= cs_n_d;
            oe_q    <= oe_d;
            dout_q  <= dout_d;
        end
    end

    assign ack_o      = ack_q;
    assign err_o      = err_q;
    assign rdata_o    = rdata_q;
    assign busy_o     = busy_q;
    assign ext_cs_n_o = cs_n_q;
    assign ext_oe_o   = oe_q;
    assign ext_dout_o = dout_q;

endmodule

// File: tb/tb_bf_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_bf_mem_responder
// Directed bench for bf_mem_responder (ADDR_W=8, TIMEOUT=4). Inputs are driven
// 1 time unit after each rising edge and outputs are sampled at the same
// point, so "cycle c" below means the c-th cycle after the request-accept
// edge. Values set after sampling cycle c take effect at the edge ending it.
// -----------------------------------------------------------------------------
module tb_bf_mem_responder;

    logic       clk;
    logic       nreset;
    logic       en_i;
    logic       req_i;
    logic       we_i;
    logic [7:0] addr_i;
    logic [7:0] wdata_i;
    logic       ack_o;
    logic       err_o;
    logic [7:0] rdata_o;
    logic       busy_o;
    logic       ext_cs_n_o;
    logic       ext_oe_o;
    logic [3:0] ext_dout_o;
    logic [3:0] ext_din_i;
    logic       ext_rdy_i;

    int compared   = 0;
    int mismatched = 0;

    bf_mem_responder #(.ADDR_W(8), .TIMEOUT(4)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .en_i       (en_i),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .rdata_o    (rdata_o),
        .busy_o     (busy_o),
        .ext_cs_n_o (ext_cs_n_o),
        .ext_oe_o   (ext_oe_o),
        .ext_dout_o (ext_dout_o),
        .ext_din_i  (ext_din_i),
        .ext_rdy_i  (ext_rdy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0; en_i = 1'b1; req_i = 1'b0; we_i = 1'b0;
        addr_i = 8'h00; wdata_i = 8'h00; ext_din_i = 4'h0; ext_rdy_i = 1'b1;
        tick(); tick();
        compared++; if (ack_o !== 1'b0)      begin mismatched++; $display("FAIL reset_ack: got %b want 0", ack_o); end
        compared++; if (err_o !== 1'b0)      begin mismatched++; $display("FAIL reset_err: got %b want 0", err_o); end
        compared++; if (rdata_o !== 8'h00)   begin mismatched++; $display("FAIL reset_rdata: got %h want 00", rdata_o); end
        compared++; if (busy_o !== 1'b0)     begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        compared++; if (ext_cs_n_o !== 1'b1) begin mismatched++; $display("FAIL reset_cs_n: got %b want 1", ext_cs_n_o); end
        compared++; if (ext_oe_o !== 1'b0)   begin mismatched++; $display("FAIL reset_oe: got %b want 0", ext_oe_o); end
        compared++; if (ext_dout_o !== 4'h0) begin mismatched++; $display("FAIL reset_dout: got %h want 0", ext_dout_o); end
        nreset = 1'b1;
        tick();
        compared++; if (busy_o !== 1'b0)     begin mismatched++; $display("FAIL reset_idle_busy: got %b want 0", busy_o); end
    endtask

    // Read of 8'h10 returning 7 then E: dout 1,1,0, TURN in cycle 4, ack in cycle 7.
    task automatic test_read();
        logic [3:0] e_dout [1:8];
        logic       e_oe   [1:8];
        logic       e_csn  [1:8];
        logic       e_ack  [1:8];
        e_dout = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        e_oe   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        e_csn  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        e_ack  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        req_i = 1'b1; we_i = 1'b0; addr_i = 8'h10; wdata_i = 8'h00; ext_rdy_i = 1'b1; ext_din_i = 4'h0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            compared++; if (ext_dout_o !== e_dout[c]) begin mismatched++; $display("FAIL read_dout c%0d: got %h want %h", c, ext_dout_o, e_dout[c]); end
            compared++; if (ext_oe_o !== e_oe[c])     begin mismatched++; $display("FAIL read_oe c%0d: got %b want %b", c, ext_oe_o, e_oe[c]); end
            compared++; if (ext_cs_n_o !== e_csn[c])  begin mismatched++; $display("FAIL read_cs_n c%0d: got %b want %b", c, ext_cs_n_o, e_csn[c]); end
            compared++; if (ack_o !== e_ack[c])       begin mismatched++; $display("FAIL read_ack c%0d: got %b want %b", c, ack_o, e_ack[c]); end
            if (c >= 7) begin
                compared++; if (rdata_o !== 8'h7E) begin mismatched++; $display("FAIL read_rdata c%0d: got %h want 7e", c, rdata_o); end
                compared++; if (err_o !== 1'b0)    begin mismatched++; $display("FAIL read_err c%0d: got %b want 0", c, err_o); end
            end
            req_i     = 1'b0;
            ext_din_i = (c == 5) ? 4'h7 : ((c == 6) ? 4'hE : 4'h0);
        end
    endtask

    // Write 8'h3C to 8'hA5 with req held and inputs scrambled while busy.
    task automatic test_write();
        logic [3:0] e_dout [1:7];
        logic       e_oe   [1:7];
        logic       e_ack  [1:7];
        logic       e_busy [1:7];
        e_dout = '{4'h2, 4'hA, 4'h5, 4'h3, 4'hC, 4'h0, 4'h0};
        e_oe   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        e_ack  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        e_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        req_i = 1'b1; we_i = 1'b1; addr_i = 8'hA5; wdata_i = 8'h3C; ext_rdy_i = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            compared++; if (ext_dout_o !== e_dout[c]) begin mismatched++; $display("FAIL write_dout c%0d: got %h want %h", c, ext_dout_o, e_dout[c]); end
            compared++; if (ext_oe_o !== e_oe[c])     begin mismatched++; $display("FAIL write_oe c%0d: got %b want %b", c, ext_oe_o, e_oe[c]); end
            compared++; if (ack_o !== e_ack[c])       begin mismatched++; $display("FAIL write_ack c%0d: got %b want %b", c, ack_o, e_ack[c]); end
            compared++; if (busy_o !== e_busy[c])     begin mismatched++; $display("FAIL write_busy c%0d: got %b want %b", c, busy_o, e_busy[c]); end
            if (c == 6) begin
                compared++; if (err_o !== 1'b0)    begin mismatched++; $display("FAIL write_err: got %b want 0", err_o); end
                compared++; if (rdata_o !== 8'h7E) begin mismatched++; $display("FAIL write_rdata_kept: got %h want 7e", rdata_o); end
                req_i = 1'b0;
            end
            if (c == 1) begin
                addr_i = 8'h00; wdata_i = 8'hFF; we_i = 1'b0;
            end
        end
    endtask

    // Read of 8'h4B with 3 stalled cycles in ADDR: ack moves from cycle 7 to 10.
    task automatic test_stall();
        logic [3:0] e_dout [1:6];
        e_dout = '{4'h1, 4'h4, 4'h4, 4'h4, 4'h4, 4'hB};
        req_i = 1'b1; we_i = 1'b0; addr_i = 8'h4B; ext_rdy_i = 1'b1; ext_din_i = 4'h0;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c <= 6) begin
                compared++; if (ext_dout_o !== e_dout[c]) begin mismatched++; $display("FAIL stall_dout c%0d: got %h want %h", c, ext_dout_o, e_dout[c]); end
            end
            compared++; if (ack_o !== (c == 10)) begin mismatched++; $display("FAIL stall_ack c%0d: got %b want %b", c, ack_o, (c == 10)); end
            if (c == 10) begin
                compared++; if (rdata_o !== 8'h96) begin mismatched++; $display("FAIL stall_rdata: got %h want 96", rdata_o); end
                compared++; if (err_o !== 1'b0)    begin mismatched++; $display("FAIL stall_err: got %b want 0", err_o); end
            end
            req_i     = 1'b0;
            ext_rdy_i = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            ext_din_i = (c == 8) ? 4'h9 : ((c == 9) ? 4'h6 : 4'h0);
        end
    endtask

    // ext_rdy stuck low in CMD: 4 stall cycles then DONE with err=1, rdata=0.
    task automatic test_timeout();
        req_i = 1'b1; we_i = 1'b0; addr_i = 8'h77; ext_rdy_i = 1'b0; ext_din_i = 4'h5;
        for (int c = 1; c <= 6; c++) begin
            tick();
            compared++; if (ack_o !== (c == 5)) begin mismatched++; $display("FAIL tmo_ack c%0d: got %b want %b", c, ack_o, (c == 5)); end
            compared++; if (err_o !== (c == 5)) begin mismatched++; $display("FAIL tmo_err c%0d: got %b want %b", c, err_o, (c == 5)); end
            if (c <= 4) begin
                compared++; if (ext_dout_o !== 4'h1) begin mismatched++; $display("FAIL tmo_dout c%0d: got %h want 1", c, ext_dout_o); end
                compared++; if (ext_cs_n_o !== 1'b0) begin mismatched++; $display("FAIL tmo_cs_n c%0d: got %b want 0", c, ext_cs_n_o); end
            end else begin
                compared++; if (rdata_o !== 8'h00)   begin mismatched++; $display("FAIL tmo_rdata c%0d: got %h want 00", c, rdata_o); end
                compared++; if (ext_cs_n_o !== 1'b1) begin mismatched++; $display("FAIL tmo_cs_n c%0d: got %b want 1", c, ext_cs_n_o); end
            end
            req_i = 1'b0;
        end
        ext_rdy_i = 1'b1; ext_din_i = 4'h0;
    endtask

    // Reset during WDATA, then a clean write of 8'hC3 to 8'h0F.
    task automatic test_reset_mid();
        logic [3:0] e_dout [1:7];
        req_i = 1'b1; we_i = 1'b1; addr_i = 8'h33; wdata_i = 8'h5A; ext_rdy_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            req_i = 1'b0;
        end
        compared++; if (ext_dout_o !== 4'h5) begin mismatched++; $display("FAIL rstmid_wdata_dout: got %h want 5", ext_dout_o); end
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        compared++; if (ext_cs_n_o !== 1'b1) begin mismatched++; $display("FAIL rstmid_cs_n: got %b want 1", ext_cs_n_o); end
        compared++; if (ext_oe_o !== 1'b0)   begin mismatched++; $display("FAIL rstmid_oe: got %b want 0", ext_oe_o); end
        compared++; if (busy_o !== 1'b0)     begin mismatched++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
        compared++; if (ack_o !== 1'b0)      begin mismatched++; $display("FAIL rstmid_ack: got %b want 0", ack_o); end
        for (int c = 0; c < 3; c++) begin
            tick();
            compared++; if (ack_o !== 1'b0) begin mismatched++; $display("FAIL rstmid_no_ack c%0d: got %b want 0", c, ack_o); end
        end
        e_dout = '{4'h2, 4'h0, 4'hF, 4'hC, 4'h3, 4'h0, 4'h0};
        req_i = 1'b1; we_i = 1'b1; addr_i = 8'h0F; wdata_i = 8'hC3;
        for (int c = 1; c <= 7; c++) begin
            tick();
            compared++; if (ext_dout_o !== e_dout[c]) begin mismatched++; $display("FAIL rstmid_wr_dout c%0d: got %h want %h", c, ext_dout_o, e_dout[c]); end
            compared++; if (ack_o !== (c == 6))       begin mismatched++; $display("FAIL rstmid_wr_ack c%0d: got %b want %b", c, ack_o, (c == 6)); end
            req_i = 1'b0;
        end
    endtask

    // en=0 for 5 cycles mid-RDATA, then en=0 for 2 cycles while in DONE.
    task automatic test_en_freeze();
        req_i = 1'b1; we_i = 1'b0; addr_i = 8'h22; ext_rdy_i = 1'b1; ext_din_i = 4'h0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c >= 6 && c <= 11) begin
                compared++; if (busy_o !== 1'b1)     begin mismatched++; $display("FAIL frz_busy c%0d: got %b want 1", c, busy_o); end
                compared++; if (ext_cs_n_o !== 1'b0) begin mismatched++; $display("FAIL frz_cs_n c%0d: got %b want 0", c, ext_cs_n_o); end
                compared++; if (ext_oe_o !== 1'b0)   begin mismatched++; $display("FAIL frz_oe c%0d: got %b want 0", c, ext_oe_o); end
                compared++; if (ext_dout_o !== 4'h0) begin mismatched++; $display("FAIL frz_dout c%0d: got %h want 0", c, ext_dout_o); end
                compared++; if (ack_o !== 1'b0)      begin mismatched++; $display("FAIL frz_ack c%0d: got %b want 0", c, ack_o); end
                compared++; if (rdata_o !== 8'h00)   begin mismatched++; $display("FAIL frz_rdata c%0d: got %h want 00", c, rdata_o); end
            end
            if (c >= 12 && c <= 14) begin
                compared++; if (ack_o !== 1'b1)    begin mismatched++; $display("FAIL frz_done_ack c%0d: got %b want 1", c, ack_o); end
                compared++; if (rdata_o !== 8'hD4) begin mismatched++; $display("FAIL frz_rdata_done c%0d: got %h want d4", c, rdata_o); end
                compared++; if (err_o !== 1'b0)    begin mismatched++; $display("FAIL frz_err c%0d: got %b want 0", c, err_o); end
            end
            if (c == 15) begin
                compared++; if (ack_o !== 1'b0)  begin mismatched++; $display("FAIL frz_after_ack: got %b want 0", ack_o); end
                compared++; if (busy_o !== 1'b0) begin mismatched++; $display("FAIL frz_after_busy: got %b want 0", busy_o); end
            end
            req_i = 1'b0;
            case (c)
                5:       begin ext_din_i = 4'hD; end
                6:       begin en_i = 1'b0; ext_din_i = 4'hF; end
                11:      begin en_i = 1'b1; ext_din_i = 4'h4; end
                12:      begin en_i = 1'b0; ext_din_i = 4'h0; end
                14:      begin en_i = 1'b1; end
                default: begin end
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_en_freeze();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
